// File: rtl/stream_dot_mac_if.sv
// Streaming bundle for the dot-product MAC: one word in per cycle, one
// registered result (or an abort pulse) out.
interface stream_dot_mac_if #(
    parameter int W = 32
);
    logic         validi;
    logic [W-1:0] data_in;
    logic         valido;
    logic [W-1:0] data_out;
    logic         overflow;
    logic         abort;

    modport master (
        output validi, data_in,
        input  valido, data_out, overflow, abort
    );

    modport slave (
        input  validi, data_in,
        output valido, data_out, overflow, abort
    );
endinterface

// File: rtl/stream_dot_mac.sv
// Streaming multiply-accumulate: frame a0,b0,...,a(T-1),b(T-1),c yields
// sum(ai*bi)+c, with optional signed arithmetic and saturation.
module stream_dot_mac #(
    parameter int W      = 32,
    parameter int TERMS  = 2,
    parameter int SIGNED = 0,
    parameter int SAT    = 0
) (
    input logic            clk,
    input logic            rst,
    stream_dot_mac_if.slave strm
);
    localparam int L    = 2 * TERMS + 1;
    localparam int IDXW = $clog2(L);
    localparam int PW   = 2 * W + 2;
    localparam int ACCW = 2 * W + $clog2(TERMS) + 2;

    localparam logic [IDXW-1:0]        LAST = IDXW'(L - 1);
    localparam logic signed [ACCW-1:0] ONE  = ACCW'(1);
    localparam logic signed [ACCW-1:0] MAXV = (SIGNED != 0) ? (ONE <<< (W - 1)) - ONE
                                                            : (ONE <<< W) - ONE;
    localparam logic signed [ACCW-1:0] MINV = (SIGNED != 0) ? -(ONE <<< (W - 1))
                                                            : ACCW'(0);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t                  state_q;
    logic [IDXW-1:0]         idx_q;
    logic signed [ACCW-1:0]  acc_q;
    logic [W-1:0]            aOp_q;
    logic                    valid_q;
    logic                    abort_q;
    logic                    ovf_q;
    logic [W-1:0]            data_q;

    logic signed [PW-1:0]    opA;
    logic signed [PW-1:0]    opB;
    logic signed [PW-1:0]    prod;
    logic signed [ACCW-1:0]  prodExt;
    logic signed [ACCW-1:0]  sumFinal;
    logic [W-1:0]            data_d;
    logic                    ovf_d;

    // Operands are widened by one bit so a single signed multiplier serves
    // both the signed and the unsigned configuration.
    always_comb begin
        opA      = (SIGNED != 0) ? PW'($signed(aOp_q))        : PW'($unsigned(aOp_q));
        opB      = (SIGNED != 0) ? PW'($signed(strm.data_in)) : PW'($unsigned(strm.data_in));
        prod     = opA * opB;
        prodExt  = ACCW'(prod);
        sumFinal = acc_q + ACCW'(opB);
        ovf_d    = (sumFinal > MAXV) || (sumFinal < MINV);
        if ((SAT != 0) && ovf_d) begin
            data_d = (sumFinal > MAXV) ? MAXV[W-1:0] : MINV[W-1:0];
        end else begin
            data_d = sumFinal[W-1:0];
        end
    end

    // Even word positions hold the pending a operand, odd positions fold
    // a*b into the accumulator, and the final position adds c and publishes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            aOp_q   <= '0;
            valid_q <= 1'b0;
            abort_q <= 1'b0;
            ovf_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= 1'b0;
            abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (strm.validi) begin
                        aOp_q   <= strm.data_in;
                        idx_q   <= IDXW'(1);
                        state_q <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (!strm.validi) begin
                        acc_q   <= '0;
                        idx_q   <= '0;
                        state_q <= IDLE;
                        abort_q <= 1'b1;
                    end else if (idx_q == LAST) begin
                        data_q  <= data_d;
                        ovf_q   <= ovf_d;
                        valid_q <= 1'b1;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        if (idx_q[0]) begin
                            acc_q <= acc_q + prodExt;
                        end else begin
                            aOp_q <= strm.data_in;
                        end
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                    acc_q   <= '0;
                end
            endcase
        end
    end

    assign strm.valido   = valid_q;
    assign strm.abort    = abort_q;
    assign strm.overflow = ovf_q;
    assign strm.data_out = data_q;
endmodule

// File: tb/tb_stream_dot_mac.sv
// Bench for stream_dot_mac: four parameterisations side by side, a frame-level
// reference model checked every cycle, plus table-driven and directed frames.
module tb_stream_dot_mac;
    localparam int NI = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic checkOn = 1'b0;

    logic        vIn [NI];
    logic [31:0] dIn [NI];
    wire         outV [NI];
    wire         outA [NI];
    wire         outO [NI];
    wire  [31:0] outD [NI];

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    // Instance k configuration: 0 = W32/T2 unsigned wrap, 1 = W8/T1 unsigned
    // wrap, 2 = W8/T1 unsigned saturate, 3 = W8/T1 signed saturate.
    function automatic int wOf(input int k);
        return (k == 0) ? 32 : 8;
    endfunction
    function automatic int termsOf(input int k);
        return (k == 0) ? 2 : 1;
    endfunction
    function automatic bit signedOf(input int k);
        return (k == 3);
    endfunction
    function automatic bit satOf(input int k);
        return (k >= 2);
    endfunction
    function automatic int frameLen(input int k);
        return 2 * termsOf(k) + 1;
    endfunction
    function automatic logic [31:0] maskOf(input int wd);
        return (wd == 32) ? 32'hFFFF_FFFF : ((32'd1 << wd) - 32'd1);
    endfunction

    stream_dot_mac_if #(.W(32)) bus0 ();
    stream_dot_mac_if #(.W(8))  bus1 ();
    stream_dot_mac_if #(.W(8))  bus2 ();
    stream_dot_mac_if #(.W(8))  bus3 ();

    stream_dot_mac #(.W(32), .TERMS(2), .SIGNED(0), .SAT(0)) dut0 (.clk(clk), .rst(rst), .strm(bus0.slave));
    stream_dot_mac #(.W(8),  .TERMS(1), .SIGNED(0), .SAT(0)) dut1 (.clk(clk), .rst(rst), .strm(bus1.slave));
    stream_dot_mac #(.W(8),  .TERMS(1), .SIGNED(0), .SAT(1)) dut2 (.clk(clk), .rst(rst), .strm(bus2.slave));
    stream_dot_mac #(.W(8),  .TERMS(1), .SIGNED(1), .SAT(1)) dut3 (.clk(clk), .rst(rst), .strm(bus3.slave));

    assign bus0.validi = vIn[0];
    assign bus1.validi = vIn[1];
    assign bus2.validi = vIn[2];
    assign bus3.validi = vIn[3];
    assign bus0.data_in = dIn[0];
    assign bus1.data_in = dIn[1][7:0];
    assign bus2.data_in = dIn[2][7:0];
    assign bus3.data_in = dIn[3][7:0];

    assign outV[0] = bus0.valido;   assign outA[0] = bus0.abort;
    assign outV[1] = bus1.valido;   assign outA[1] = bus1.abort;
    assign outV[2] = bus2.valido;   assign outA[2] = bus2.abort;
    assign outV[3] = bus3.valido;   assign outA[3] = bus3.abort;
    assign outO[0] = bus0.overflow; assign outD[0] = bus0.data_out;
    assign outO[1] = bus1.overflow; assign outD[1] = {24'd0, bus1.data_out};
    assign outO[2] = bus2.overflow; assign outD[2] = {24'd0, bus2.data_out};
    assign outO[3] = bus3.overflow; assign outD[3] = {24'd0, bus3.data_out};

    // Word interpreted as an exact integer under the instance's signedness.
    function automatic logic signed [127:0] toInt(input logic [31:0] x, input int wd, input bit sg);
        logic signed [127:0] v;
        v = $signed({96'd0, x & maskOf(wd)});
        if (sg && x[wd-1]) v = v - (128'sd1 <<< wd);
        return v;
    endfunction

    // Exact frame result in wide arithmetic, then range check and wrap/clamp.
    function automatic logic [32:0] evalFrame(input int k, input logic [4:0][31:0] w, input logic [31:0] c);
        logic signed [127:0] acc, hi, lo;
        int  wd;
        bit  ovf;
        wd  = wOf(k);
        acc = toInt(c, wd, signedOf(k));
        for (int i = 0; i < termsOf(k); i++)
            acc = acc + toInt(w[2*i], wd, signedOf(k)) * toInt(w[2*i+1], wd, signedOf(k));
        if (signedOf(k)) begin
            hi = (128'sd1 <<< (wd - 1)) - 128'sd1;
            lo = -(128'sd1 <<< (wd - 1));
        end else begin
            hi = (128'sd1 <<< wd) - 128'sd1;
            lo = 128'sd0;
        end
        ovf = (acc > hi) || (acc < lo);
        if (satOf(k) && ovf) acc = (acc > hi) ? hi : lo;
        return {ovf, acc[31:0] & maskOf(wd)};
    endfunction

    logic [4:0][31:0] fw   [NI];
    int               fcnt [NI];
    logic             expV [NI];
    logic             expA [NI];
    logic             expO [NI];
    logic [31:0]      expD [NI];

    // Frame-level reference: buffer words, evaluate on the last one, abort a
    // non-empty buffer on a gap, forget everything on reset.
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                fcnt[k] <= 0;
                expV[k] <= 1'b0;
                expA[k] <= 1'b0;
                expO[k] <= 1'b0;
                expD[k] <= 32'd0;
            end else begin
                expV[k] <= 1'b0;
                expA[k] <= 1'b0;
                if (vIn[k]) begin
                    if (fcnt[k] == frameLen(k) - 1) begin
                        {expO[k], expD[k]} <= evalFrame(k, fw[k], dIn[k]);
                        expV[k] <= 1'b1;
                        fcnt[k] <= 0;
                    end else begin
                        fw[k][fcnt[k]] <= dIn[k] & maskOf(wOf(k));
                        fcnt[k] <= fcnt[k] + 1;
                    end
                end else if (fcnt[k] != 0) begin
                    fcnt[k] <= 0;
                    expA[k] <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checkOn) begin
            for (int k = 0; k < NI; k++) begin
                nTests++;
                if ({outV[k], outA[k], outO[k], outD[k]} !== {expV[k], expA[k], expO[k], expD[k]}) begin
                    nFail++;
                    $display("[TB] FAIL model inst%0d: got v=%0b a=%0b o=%0b d=%h, want v=%0b a=%0b o=%0b d=%h",
                             k, outV[k], outA[k], outO[k], outD[k], expV[k], expA[k], expO[k], expD[k]);
                end
            end
        end
    end

    typedef struct packed {
        logic [1:0]       inst;
        logic [4:0][31:0] w;
        logic [31:0]      expD;
        logic             expO;
    } vec_t;

    function automatic vec_t mk(input int k, input logic [31:0] a, b, c, d, e,
                                input logic [31:0] ed, input logic eo);
        vec_t v;
        v.inst = 2'(k);
        v.w    = {e, d, c, b, a};
        v.expD = ed;
        v.expO = eo;
        return v;
    endfunction

    task automatic applyStimulus(input int k, input logic [4:0][31:0] w);
        for (int i = 0; i < frameLen(k); i++) begin
            vIn[k] = 1'b1;
            dIn[k] = w[i];
            @(negedge clk);
        end
    endtask

    task automatic checkOutput(input string name, input int k, input logic ev, ea,
                               input logic [31:0] ed, input logic eo);
        nTests++;
        if ({outV[k], outA[k], outO[k], outD[k]} !== {ev, ea, eo, ed}) begin
            nFail++;
            $display("[TB] FAIL %s inst%0d: got v=%0b a=%0b o=%0b d=%h, want v=%0b a=%0b o=%0b d=%h",
                     name, k, outV[k], outA[k], outO[k], outD[k], ev, ea, eo, ed);
        end
    endtask

    vec_t        tbl [18];
    logic [31:0] lastD [NI];
    logic        lastO [NI];
    logic [4:0][31:0] seq;

    initial begin
        tbl[0]  = mk(0, 3, 4, 5, 6, 7, 32'd49, 1'b0);
        tbl[1]  = mk(0, 1, 1, 1, 1, 1, 32'd3, 1'b0);
        tbl[2]  = mk(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 32'd1, 1'b1);
        tbl[3]  = mk(0, 32'hFFFF_FFFF, 1, 1, 1, 0, 32'd0, 1'b1);
        tbl[4]  = mk(0, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        tbl[5]  = mk(0, 32'h1_0000, 32'h1_0000, 0, 0, 5, 32'd5, 1'b1);
        tbl[6]  = mk(1, 16, 16, 5, 0, 0, 32'd5, 1'b1);
        tbl[7]  = mk(1, 15, 17, 0, 0, 0, 32'd255, 1'b0);
        tbl[8]  = mk(1, 15, 17, 1, 0, 0, 32'd0, 1'b1);
        tbl[9]  = mk(2, 16, 16, 5, 0, 0, 32'd255, 1'b1);
        tbl[10] = mk(2, 15, 17, 0, 0, 0, 32'd255, 1'b0);
        tbl[11] = mk(2, 3, 4, 5, 0, 0, 32'd17, 1'b0);
        tbl[12] = mk(3, 32'h80, 2, 0, 0, 0, 32'h80, 1'b1);
        tbl[13] = mk(3, 32'hFD, 4, 2, 0, 0, 32'hF6, 1'b0);
        tbl[14] = mk(3, 32'h80, 32'h80, 0, 0, 0, 32'h7F, 1'b1);
        tbl[15] = mk(3, 32'h7F, 1, 0, 0, 0, 32'h7F, 1'b0);
        tbl[16] = mk(3, 32'h80, 1, 0, 0, 0, 32'h80, 1'b0);
        tbl[17] = mk(3, 32'hFF, 32'hFF, 32'h7F, 0, 0, 32'h7F, 1'b1);

        for (int k = 0; k < NI; k++) begin
            vIn[k] = 1'b0;
            dIn[k] = 32'd0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) checkOutput("reset_state", k, 1'b0, 1'b0, 32'd0, 1'b0);
        rst = 1'b0;
        checkOn = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_quiet", 0, 1'b0, 1'b0, 32'd0, 1'b0);

        // Table frames; consecutive rows of one instance run with no bubble.
        for (int i = 0; i < 18; i++) begin
            applyStimulus(int'(tbl[i].inst), tbl[i].w);
            checkOutput("table_result", int'(tbl[i].inst), 1'b1, 1'b0, tbl[i].expD, tbl[i].expO);
            lastD[tbl[i].inst] = tbl[i].expD;
            lastO[tbl[i].inst] = tbl[i].expO;
            if (i == 17 || tbl[i+1].inst != tbl[i].inst) begin
                vIn[tbl[i].inst] = 1'b0;
                @(negedge clk);
                checkOutput("table_hold", int'(tbl[i].inst), 1'b0, 1'b0, tbl[i].expD, tbl[i].expO);
            end
        end

        // Gap inside a frame: abort pulse, result registers untouched.
        seq = {32'd0, 32'd0, 32'd5, 32'd4, 32'd3};
        for (int i = 0; i < 3; i++) begin
            vIn[0] = 1'b1;
            dIn[0] = seq[i];
            @(negedge clk);
        end
        vIn[0] = 1'b0;
        @(negedge clk);
        checkOutput("abort_pulse", 0, 1'b0, 1'b1, lastD[0], lastO[0]);
        @(negedge clk);
        checkOutput("abort_clear", 0, 1'b0, 1'b0, lastD[0], lastO[0]);
        applyStimulus(0, {32'd2, 32'd2, 32'd2, 32'd2, 32'd2});
        checkOutput("after_abort", 0, 1'b1, 1'b0, 32'd10, 1'b0);

        // Reset in the middle of a frame.
        seq = {32'd0, 32'd0, 32'd0, 32'd4, 32'd3};
        for (int i = 0; i < 2; i++) begin
            vIn[0] = 1'b1;
            dIn[0] = seq[i];
            @(negedge clk);
        end
        vIn[0] = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rst_async", 0, 1'b0, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_no_abort", 0, 1'b0, 1'b0, 32'd0, 1'b0);
        applyStimulus(0, {32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
        checkOutput("after_rst", 0, 1'b1, 1'b0, 32'd19, 1'b0);
        vIn[0] = 1'b0;
        @(negedge clk);
        checkOutput("after_rst_hold", 0, 1'b0, 1'b0, 32'd19, 1'b0);

        // Random streams on all instances, with gaps, extremes and one reset.
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int k = 0; k < NI; k++) begin
                vIn[k] = ($urandom_range(0, 9) != 0);
                case ($urandom_range(0, 3))
                    0:       dIn[k] = 32'd0;
                    1:       dIn[k] = maskOf(wOf(k));
                    2:       dIn[k] = 32'd1 << (wOf(k) - 1);
                    default: dIn[k] = $urandom & maskOf(wOf(k));
                endcase
            end
            rst = (cyc == 400);
            @(negedge clk);
        end
        rst = 1'b0;
        for (int k = 0; k < NI; k++) vIn[k] = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule

// File: doc/stream_dot_mac.md
STREAM_DOT_MAC -- requirements
Module: stream_dot_mac

Interface
REQ-001 Parameter W, default 32, data width in bits (W >= 2).
REQ-002 Parameter TERMS, default 2, product pairs per frame (TERMS >= 1); frame length L = 2*TERMS+1 words.
REQ-003 Parameter SIGNED, default 0; 1 = all operands and result two's complement, 0 = unsigned.
REQ-004 Parameter SAT, default 0; 1 = saturate the result on overflow, 0 = wrap modulo 2^W.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 validi  input  1  data_in carries a frame word this cycle.
REQ-008 data_in  input  W  frame word.
REQ-009 valido  output  1  one-cycle pulse: data_out and overflow hold a new result.
REQ-010 data_out  output  W  result, registered.
REQ-011 overflow  output  1  result of the frame that raised valido was not representable in W bits; registered.
REQ-012 abort  output  1  one-cycle pulse: a partial frame was discarded.

Function
REQ-013 A frame SHALL be L words accepted on L consecutive cycles with validi=1, in order a0,b0,a1,b1,...,a(TERMS-1),b(TERMS-1),c.
REQ-014 Result SHALL equal sum over i of (ai*bi) + c, computed exactly in an internal accumulator of at least 2W+clog2(TERMS)+1 bits.
REQ-015 Block SHALL track position with a word index 0..L-1; states IDLE (index 0, no frame open) and COLLECT (index 1..L-1).
REQ-016 IDLE + validi=1: capture word as a0, go to COLLECT, index 1; IDLE + validi=0: stay, no outputs pulsed.
REQ-017 COLLECT + validi=1: consume word, index+1; at index L-1 the word is c, the frame completes, and the block returns to IDLE (index 0).
REQ-018 COLLECT + validi=0: discard the partial frame, clear the accumulator, return to IDLE, pulse abort=1 for exactly the next cycle.
REQ-019 Latency: valido=1 on the cycle following the clock edge that captures c, for exactly one cycle, with data_out and overflow updated at that same edge.
REQ-020 Back-to-back frames SHALL be accepted without bubble: a validi=1 word on the cycle after c is a0 of the next frame.
REQ-021 data_out and overflow SHALL hold their last values while valido=0; abort SHALL NOT change them.
REQ-022 Overflow, SIGNED=0: exact result > 2^W-1; SIGNED=1: exact result outside [-2^(W-1), 2^(W-1)-1].
REQ-023 SAT=0: data_out = low W bits of exact result; SAT=1 and overflow: data_out = max representable if result positive, min representable if negative.
REQ-024 valido and abort SHALL never be 1 in the same cycle.

Reset
REQ-025 rst=1 SHALL immediately force valido=0, abort=0, overflow=0, data_out=0, index=0, state IDLE, accumulator=0.
REQ-026 rst asserted mid-frame SHALL discard the partial frame with no abort pulse; the first validi=1 word after rst deasserts is a0.
REQ-027 No output SHALL pulse in the cycle rst deasserts unless a prior word was captured.

Verification
REQ-028 W=32,TERMS=2,unsigned: words 3,4,5,6,7 on 5 consecutive cycles -> next cycle valido=1, data_out=49, overflow=0; valido=0 the cycle after.
REQ-029 Back-to-back: 3,4,5,6,7 then 1,1,1,1,1 with no gap -> valido pulses two cycles apart by 5, data_out 49 then 3.
REQ-030 Gap: 3,4,5 then validi=0 -> abort=1 one cycle, valido stays 0, data_out unchanged; following 2,2,2,2,2 -> data_out=10.
REQ-031 W=8,TERMS=1,SAT=0: 16,16,5 -> data_out=5, overflow=1; same with SAT=1 -> data_out=255, overflow=1.
REQ-032 W=8,TERMS=1,SIGNED=1,SAT=1: -128,2,0 -> data_out=-128 (0x80), overflow=1; -3,4,2 -> data_out=-10 (0xF6), overflow=0.
REQ-033 Reset mid-frame: 3,4 then rst pulse -> all outputs 0, no abort; then 1,2,3,4,5 -> data_out=19, valido one cycle.
